cv32e40p_xif_copro_mux: RTL
===========================

Name: cv32e40p_xif_copro_mux

Overview:
- Parametrised X-interface fan-out between one cv32e40p core and NUM_COPRO coprocessors, e.g. an FPU subsystem plus further accelerators.
- Issue requests are broadcast to all coprocessors. An ownership table indexed by instruction ID records which coprocessor accepted each instruction.
- Commit transactions are routed to the owner only.
- Coprocessor results are round-robin arbitrated into one registered result channel towards the core.
- Sits between the core wrapper and the coprocessor instances, replacing the one-to-one hookup.

Parameters:
NUM_COPRO, 2, number of coprocessor ports (1..8)
ID_WIDTH, 4, instruction ID width; ownership table has 2**ID_WIDTH entries
DATA_WIDTH, 32, result data width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
x_issue_valid_i  in  1  core issue valid
x_issue_ready_o  out  1  issue ready to core
x_issue_instr_i  in  32  offloaded instruction
x_issue_id_i  in  ID_WIDTH  instruction ID
x_issue_accept_o  out  1  some coprocessor accepted
x_issue_writeback_o  out  1  owner will write rd
x_issue_valid_o  out  NUM_COPRO  per-coprocessor issue valid
x_issue_ready_i  in  NUM_COPRO  per-coprocessor ready
x_issue_instr_o  out  32  broadcast instruction
x_issue_id_o  out  ID_WIDTH  broadcast ID
x_issue_accept_i  in  NUM_COPRO  per-coprocessor accept
x_issue_writeback_i  in  NUM_COPRO  per-coprocessor writeback
x_commit_valid_i  in  1  core commit valid
x_commit_id_i  in  ID_WIDTH  commit ID
x_commit_kill_i  in  1  kill flag
x_commit_valid_o  out  NUM_COPRO  routed commit valid
x_commit_id_o  out  ID_WIDTH  broadcast commit ID
x_commit_kill_o  out  1  broadcast kill
x_result_valid_i  in  NUM_COPRO  coprocessor result valid
x_result_ready_o  out  NUM_COPRO  coprocessor result ready
x_result_id_i  in  NUM_COPRO*ID_WIDTH  packed result IDs, port k at [k*ID_WIDTH +: ID_WIDTH]
x_result_data_i  in  NUM_COPRO*DATA_WIDTH  packed result data
x_result_rd_i  in  NUM_COPRO*5  packed destination registers
x_result_we_i  in  NUM_COPRO  packed write enables
x_result_valid_o  out  1  result valid to core
x_result_ready_i  in  1  core result ready
x_result_id_o  out  ID_WIDTH  result ID
x_result_data_o  out  DATA_WIDTH  result data
x_result_rd_o  out  5  result rd
x_result_we_o  out  1  result we
x_err_o  out  1  one-cycle pulse on protocol error

Behaviour:
- State: per ID, busy, owner[$clog2(NUM_COPRO)], wb and committed. Also a round-robin pointer and a one-entry result output register.
- Reset: all table bits 0, pointer 0, output register empty. Consequently x_result_valid_o=0, x_err_o=0 and the x_result_*_o data outputs are 0.
- Issue gating: stall = busy[x_issue_id_i].
  - x_issue_valid_o[k] = x_issue_valid_i & ~stall for every k.
  - x_issue_ready_o = &x_issue_ready_i & ~stall.
  - Issue fires when x_issue_valid_i & x_issue_ready_o.
- Issue decision: x_issue_accept_o = |x_issue_accept_i.
  - The owner is the lowest-index accepting coprocessor.
  - x_issue_writeback_o = x_issue_writeback_i[owner].
  - More than one accept in the same cycle pulses x_err_o; the lowest index still wins.
- Issue table update: on fire with accept, set busy=1, owner, wb and committed=0 for that ID. With no accept, the table is unchanged.
- Commit routing: x_commit_valid_o[k] = x_commit_valid_i & busy[id] & (owner[id]==k).
  - A commit to a non-busy ID is dropped; this is not an error, since it covers rejected instructions.
- Commit table update:
  - kill clears busy.
  - Non-kill with wb=0 clears busy.
  - Non-kill with wb=1 sets committed=1.
- Result arbitration: round-robin over x_result_valid_i, starting at the pointer.
  - The output register loads when it is empty or is handshaking this cycle (load = ~full | x_result_ready_i).
  - x_result_ready_o[k] = grant[k] & load.
  - On load, the pointer advances to grant+1 mod NUM_COPRO.
  - Latency from coprocessor handshake to x_result_valid_o is 1 cycle.
  - Back-to-back throughput is 1 result per cycle.
  - Output data holds stable while valid & ~ready.
- Result completion: on the coprocessor-side handshake, busy[id] is cleared.
  - A result for a non-busy ID, or from a port other than owner[id], is still forwarded and pulses x_err_o.
- Same-cycle events:
  - Table updates from issue, commit and result apply in the same cycle to distinct IDs.
  - Clear wins over set for the same ID, which can only happen with an erroneous result; x_err_o also pulses.
  - A clear does not bypass to the issue stall; a reissue of the same ID waits one cycle.
- Reset mid-operation: all state is dropped and in-flight results are lost. Coprocessors are reset by the same rst_i.

Test Plan:
- Issue ID 3 with accept_i=2'b10, writeback=1, then commit ID 3 non-kill -> x_issue_accept_o=1, x_commit_valid_o=2'b10; a result from port 1 with ID 3 and data 0xDEADBEEF appears one cycle later with x_result_rd_o matching; busy[3] clears.
- Issue ID 5, accept_i=2'b00 -> accept_o=0; a later commit ID 5 gives x_commit_valid_o=0 and x_err_o=0.
- Issue ID 2 accepted by port 0, then reissue ID 2 before its result -> x_issue_ready_o=0 and x_issue_valid_o=0 until the cycle after the result handshake.
- Both ports hold valid results with x_result_ready_i=1 -> grants alternate 0,1,0,1. With ready held low for 3 cycles, the output stays stable and x_result_ready_o=0.
- Issue ID 1 to port 0 with writeback=1, then commit kill -> busy clears, and ID 1 can issue again the next cycle.
- accept_i=2'b11 -> owner is port 0 and x_err_o pulses for exactly 1 cycle. Then assert rst_i mid-transaction -> x_result_valid_o=0 and all IDs issue without stall.

Source files
------------

// File: rtl/cv32e40p_xif_copro_mux_if.sv
// X-interface bundle between the core/coprocessor side and the coprocessor mux.
// The slave modport is the mux; the master modport is the surrounding environment.
interface cv32e40p_xif_copro_mux_if #(
    parameter int unsigned NUM_COPRO  = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                            x_issue_valid_i;
    logic                            x_issue_ready_o;
    logic [31:0]                     x_issue_instr_i;
    logic [ID_WIDTH-1:0]             x_issue_id_i;
    logic                            x_issue_accept_o;
    logic                            x_issue_writeback_o;
    logic [NUM_COPRO-1:0]            x_issue_valid_o;
    logic [NUM_COPRO-1:0]            x_issue_ready_i;
    logic [31:0]                     x_issue_instr_o;
    logic [ID_WIDTH-1:0]             x_issue_id_o;
    logic [NUM_COPRO-1:0]            x_issue_accept_i;
    logic [NUM_COPRO-1:0]            x_issue_writeback_i;
    logic                            x_commit_valid_i;
    logic [ID_WIDTH-1:0]             x_commit_id_i;
    logic                            x_commit_kill_i;
    logic [NUM_COPRO-1:0]            x_commit_valid_o;
    logic [ID_WIDTH-1:0]             x_commit_id_o;
    logic                            x_commit_kill_o;
    logic [NUM_COPRO-1:0]            x_result_valid_i;
    logic [NUM_COPRO-1:0]            x_result_ready_o;
    logic [NUM_COPRO*ID_WIDTH-1:0]   x_result_id_i;
    logic [NUM_COPRO*DATA_WIDTH-1:0] x_result_data_i;
    logic [NUM_COPRO*5-1:0]          x_result_rd_i;
    logic [NUM_COPRO-1:0]            x_result_we_i;
    logic                            x_result_valid_o;
    logic                            x_result_ready_i;
    logic [ID_WIDTH-1:0]             x_result_id_o;
    logic [DATA_WIDTH-1:0]           x_result_data_o;
    logic [4:0]                      x_result_rd_o;
    logic                            x_result_we_o;
    logic                            x_err_o;

    modport slave (
        input  x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_ready_i,
               x_issue_accept_i, x_issue_writeback_i, x_commit_valid_i, x_commit_id_i,
               x_commit_kill_i, x_result_valid_i, x_result_id_i, x_result_data_i,
               x_result_rd_i, x_result_we_i, x_result_ready_i,
        output x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o, x_issue_valid_o,
               x_issue_instr_o, x_issue_id_o, x_commit_valid_o, x_commit_id_o,
               x_commit_kill_o, x_result_ready_o, x_result_valid_o, x_result_id_o,
               x_result_data_o, x_result_rd_o, x_result_we_o, x_err_o
    );

    modport master (
        output x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_ready_i,
               x_issue_accept_i, x_issue_writeback_i, x_commit_valid_i, x_commit_id_i,
               x_commit_kill_i, x_result_valid_i, x_result_id_i, x_result_data_i,
               x_result_rd_i, x_result_we_i, x_result_ready_i,
        input  x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o, x_issue_valid_o,
               x_issue_instr_o, x_issue_id_o, x_commit_valid_o, x_commit_id_o,
               x_commit_kill_o, x_result_ready_o, x_result_valid_o, x_result_id_o,
               x_result_data_o, x_result_rd_o, x_result_we_o, x_err_o
    );
endinterface

// File: rtl/cv32e40p_xif_copro_mux.sv
// X-interface fan-out from one core to NUM_COPRO coprocessors: broadcast issue,
// owner-routed commit via a per-ID ownership table, round-robin registered results.
module cv32e40p_xif_copro_mux #(
    parameter int unsigned NUM_COPRO  = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                     clk_i,
    input logic                     rst_i,
    cv32e40p_xif_copro_mux_if.slave xif
);
    localparam int unsigned OW    = (NUM_COPRO > 1) ? $clog2(NUM_COPRO) : 1;
    localparam int unsigned DEPTH = 2**ID_WIDTH;

    logic [DEPTH-1:0]      busy_q, busy_d, wb_q, wb_d, committed_q, committed_d;
    logic [OW-1:0]         owner_q [DEPTH];
    logic [OW-1:0]         owner_d [DEPTH];
    logic [OW-1:0]         ptr_q, ptr_d;
    logic                  full_q, full_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [4:0]            out_rd_q, out_rd_d;
    logic                  out_we_q, out_we_d;
    logic                  err_q, err_d;

    logic                  stall, issue_fire, multi_accept, found;
    logic [OW-1:0]         iss_owner;
    logic                  gvalid, load, res_hs;
    int unsigned           g_int, idx;
    logic [OW-1:0]         grant;
    logic [ID_WIDTH-1:0]   rid;

    // Issue side: broadcast, stall on a still-owned ID, lowest accepting port owns it
    assign stall        = busy_q[xif.x_issue_id_i];
    assign issue_fire   = xif.x_issue_valid_i & xif.x_issue_ready_o;
    assign multi_accept = |(xif.x_issue_accept_i & (xif.x_issue_accept_i - NUM_COPRO'(1)));

    assign xif.x_issue_valid_o     = {NUM_COPRO{xif.x_issue_valid_i & ~stall}};
    assign xif.x_issue_ready_o     = (&xif.x_issue_ready_i) & ~stall;
    assign xif.x_issue_accept_o    = |xif.x_issue_accept_i;
    assign xif.x_issue_writeback_o = xif.x_issue_writeback_i[iss_owner];
    assign xif.x_issue_instr_o     = xif.x_issue_instr_i;
    assign xif.x_issue_id_o        = xif.x_issue_id_i;
    assign xif.x_commit_id_o       = xif.x_commit_id_i;
    assign xif.x_commit_kill_o     = xif.x_commit_kill_i;

    always_comb begin
        iss_owner = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NUM_COPRO; k++) begin
            if (xif.x_issue_accept_i[k] && !found) begin
                iss_owner = OW'(k);
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        xif.x_commit_valid_o = '0;
        for (int unsigned k = 0; k < NUM_COPRO; k++) begin
            xif.x_commit_valid_o[k] = xif.x_commit_valid_i & busy_q[xif.x_commit_id_i]
                                    & (owner_q[xif.x_commit_id_i] == OW'(k));
        end
    end

    // Round-robin scan starting at ptr_q, wrapping without a modulo
    always_comb begin
        gvalid = 1'b0;
        g_int  = 0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_COPRO; i++) begin
            idx = i + 32'(ptr_q);
            if (idx >= NUM_COPRO) idx = idx - NUM_COPRO;
            if (xif.x_result_valid_i[idx] && !gvalid) begin
                gvalid = 1'b1;
                g_int  = idx;
            end
        end
    end

    assign grant  = OW'(g_int);
    assign load   = ~full_q | xif.x_result_ready_i;
    assign res_hs = gvalid & load;
    assign rid    = xif.x_result_id_i[g_int*ID_WIDTH +: ID_WIDTH];

    always_comb begin
        xif.x_result_ready_o = '0;
        for (int unsigned k = 0; k < NUM_COPRO; k++) begin
            xif.x_result_ready_o[k] = res_hs & (g_int == k);
        end
    end

    assign xif.x_result_valid_o = full_q;
    assign xif.x_result_id_o    = out_id_q;
    assign xif.x_result_data_o  = out_data_q;
    assign xif.x_result_rd_o    = out_rd_q;
    assign xif.x_result_we_o    = out_we_q;
    assign xif.x_err_o          = err_q;

    // Update order issue -> commit -> result makes a result clear win over an issue set
    always_comb begin
        busy_d      = busy_q;
        wb_d        = wb_q;
        committed_d = committed_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        err_d       = 1'b0;

        if (issue_fire && xif.x_issue_accept_o) begin
            busy_d[xif.x_issue_id_i]      = 1'b1;
            owner_d[xif.x_issue_id_i]     = iss_owner;
            wb_d[xif.x_issue_id_i]        = xif.x_issue_writeback_i[iss_owner];
            committed_d[xif.x_issue_id_i] = 1'b0;
            err_d                         = multi_accept;
        end

        if (xif.x_commit_valid_i && busy_q[xif.x_commit_id_i]) begin
            if (xif.x_commit_kill_i || !wb_q[xif.x_commit_id_i])
                busy_d[xif.x_commit_id_i] = 1'b0;
            else
                committed_d[xif.x_commit_id_i] = 1'b1;
        end

        if (load) begin
            full_d = gvalid;
            if (gvalid) begin
                out_id_d   = rid;
                out_data_d = xif.x_result_data_i[g_int*DATA_WIDTH +: DATA_WIDTH];
                out_rd_d   = xif.x_result_rd_i[g_int*5 +: 5];
                out_we_d   = xif.x_result_we_i[g_int];
                ptr_d      = (g_int + 1 >= NUM_COPRO) ? '0 : OW'(g_int + 1);
            end
        end

        if (res_hs) begin
            busy_d[rid] = 1'b0;
            if (!busy_q[rid] || owner_q[rid] != grant) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            wb_q        <= '0;
            committed_q <= '0;
            owner_q     <= '{default: '0};
            ptr_q       <= '0;
            full_q      <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wb_q        <= wb_d;
            committed_q <= committed_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
            err_q       <= err_d;
        end
    end
endmodule
